// File: rtl/ex_alu_issue_pkg.sv
// ex_alu_issue_pkg: opcode/funct3 encodings, ALU strobe indices and FSM/operand-select types
// shared by the EX-stage ALU issue block and its decoder.
package ex_alu_issue_pkg;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [3:0] SEL_ADD  = 4'd0;
   localparam logic [3:0] SEL_SUB  = 4'd1;
   localparam logic [3:0] SEL_SLT  = 4'd2;
   localparam logic [3:0] SEL_SLTU = 4'd3;
   localparam logic [3:0] SEL_XOR  = 4'd4;
   localparam logic [3:0] SEL_OR   = 4'd5;
   localparam logic [3:0] SEL_AND  = 4'd6;
   localparam logic [3:0] SEL_SLL  = 4'd7;
   localparam logic [3:0] SEL_SRL  = 4'd8;
   localparam logic [3:0] SEL_SRA  = 4'd9;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {A_RS1, A_ZERO, A_PC} a_src_t;
   typedef enum logic {B_RS2, B_IMM} b_src_t;
   // alt selects sub/sra; it has no meaning for the other funct3 values
   function automatic logic [9:0] alu_sel(input logic [2:0] f3, input logic alt);
      logic [3:0] idx;
      idx = SEL_ADD;
      case (f3)
         F3_ADD:  idx = alt ? SEL_SUB : SEL_ADD;
         F3_SLL:  idx = SEL_SLL;
         F3_SLT:  idx = SEL_SLT;
         F3_SLTU: idx = SEL_SLTU;
         F3_XOR:  idx = SEL_XOR;
         F3_SR:   idx = alt ? SEL_SRA : SEL_SRL;
         F3_OR:   idx = SEL_OR;
         F3_AND:  idx = SEL_AND;
      endcase
      return 10'd1 << idx;
   endfunction
endpackage

// File: rtl/ex_alu_decode.sv
// ex_alu_decode: maps opcode/funct fields to one-hot ALU strobes, operand sources and an illegal flag.
module ex_alu_decode
   import ex_alu_issue_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [9:0] sel,
   output a_src_t     a_src,
   output b_src_t     b_src,
   output logic       illegal
);
   always_comb begin
      sel = '0;
      a_src = A_RS1;
      b_src = B_RS2;
      illegal = 1'b0;
      case (opcode)
         OPC_OP: sel = alu_sel(funct3, funct7_5);
         OPC_OP_IMM: begin
            // immediate bit 30 only distinguishes srai from srli; addi never becomes sub
            sel = alu_sel(funct3, funct7_5 && funct3 == F3_SR);
            b_src = B_IMM;
         end
         OPC_LUI: begin
            sel = alu_sel(F3_ADD, 1'b0);
            a_src = A_ZERO;
            b_src = B_IMM;
         end
         OPC_AUIPC: begin
            sel = alu_sel(F3_ADD, 1'b0);
            a_src = A_PC;
            b_src = B_IMM;
         end
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/ex_alu_issue.sv
// ex_alu_issue: accepts decoded instructions from ID, drives the ALU until finish or timeout,
// and hands the captured result to WB over a valid/ready handshake.
module ex_alu_issue
   import ex_alu_issue_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_id_valid,
   output logic            o_id_ready,
   input  logic [6:0]      i_opcode,
   input  logic [2:0]      i_funct3,
   input  logic            i_funct7_5,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [XLEN-1:0] i_imm,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_flush,
   output logic [9:0]      o_alu_sel,
   output logic            o_alu_c_e,
   output logic [XLEN-1:0] o_alu_a,
   output logic [XLEN-1:0] o_alu_b,
   output logic [XLEN-1:0] o_alu_c,
   input  logic [XLEN-1:0] i_alu_y,
   input  logic            i_alu_finish,
   output logic            o_wb_valid,
   input  logic            i_wb_ready,
   output logic [XLEN-1:0] o_wb_data,
   output logic [4:0]      o_wb_rd,
   output logic            o_illegal,
   output logic            o_err
);
   state_t          state;
   logic [TO_W-1:0] cnt;
   logic [9:0]      dec_sel;
   a_src_t          a_src;
   b_src_t          b_src;
   logic            dec_illegal;
   logic [XLEN-1:0] a_nxt, b_raw, b_nxt;

   ex_alu_decode u_decode (
      .opcode   (i_opcode),
      .funct3   (i_funct3),
      .funct7_5 (i_funct7_5),
      .sel      (dec_sel),
      .a_src    (a_src),
      .b_src    (b_src),
      .illegal  (dec_illegal)
   );

   assign o_id_ready = state == S_IDLE || (state == S_DONE && i_wb_ready);
   assign a_nxt = a_src == A_ZERO ? '0 : a_src == A_PC ? i_pc : i_rs1_data;
   assign b_raw = b_src == B_IMM ? i_imm : i_rs2_data;
   assign b_nxt = |dec_sel[SEL_SRA:SEL_SLL] ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
   assign o_alu_c_e = 1'b0;
   assign o_alu_c = '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         cnt <= '0;
         o_alu_sel <= '0;
         o_alu_a <= '0;
         o_alu_b <= '0;
         o_wb_valid <= 1'b0;
         o_wb_data <= '0;
         o_wb_rd <= '0;
         o_illegal <= 1'b0;
         o_err <= 1'b0;
      end else begin
         o_illegal <= 1'b0;
         o_err <= 1'b0;
         if (i_flush) begin
            state <= S_IDLE;
            cnt <= '0;
            o_alu_sel <= '0;
            o_wb_valid <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: if (o_id_ready) begin
                  // result (if any) has been taken; a new handshake may start the next op
                  state <= S_IDLE;
                  o_wb_valid <= 1'b0;
                  if (i_id_valid && dec_illegal) o_illegal <= 1'b1;
                  else if (i_id_valid) begin
                     state <= S_ISSUE;
                     o_alu_sel <= dec_sel;
                     o_alu_a <= a_nxt;
                     o_alu_b <= b_nxt;
                     o_wb_rd <= i_rd_addr;
                  end
               end
               S_ISSUE, S_WAIT: if (i_alu_finish) begin
                  state <= S_DONE;
                  cnt <= '0;
                  o_alu_sel <= '0;
                  o_wb_data <= i_alu_y;
                  o_wb_valid <= 1'b1;
               end else if (state == S_ISSUE) begin
                  state <= S_WAIT;
                  cnt <= TO_W'(1);
               end else if (cnt == TO_W'(TIMEOUT)) begin
                  state <= S_IDLE;
                  cnt <= '0;
                  o_alu_sel <= '0;
                  o_err <= 1'b1;
               end else cnt <= cnt + 1'b1;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ex_alu_issue.sv
// tb_ex_alu_issue: directed and randomized checks of the ALU issue block against an
// instruction-level reference model and a behavioural ALU.
module tb_ex_alu_issue;
   localparam int TIMEOUT = 16;
   localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        id_valid = 1'b0, id_ready;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7_5 = 1'b0;
   logic [31:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
   logic [4:0]  rd = '0;
   logic        flush = 1'b0;
   logic [9:0]  alu_sel;
   logic        alu_c_e;
   logic [31:0] alu_a, alu_b, alu_c, alu_y;
   logic        fin = 1'b0;
   logic        wb_valid, wb_ready = 1'b0;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        illegal, err;
   int          checks = 0, errors = 0;
   logic [9:0]  es;
   logic [31:0] ea, eb, ey;
   logic [4:0]  erd;

   always #5 clk = ~clk;

   ex_alu_issue #(.XLEN(32), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .o_id_ready(id_ready),
      .i_opcode(opcode), .i_funct3(funct3), .i_funct7_5(funct7_5), .i_pc(pc),
      .i_rs1_data(rs1), .i_rs2_data(rs2), .i_imm(imm), .i_rd_addr(rd), .i_flush(flush),
      .o_alu_sel(alu_sel), .o_alu_c_e(alu_c_e), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_c(alu_c),
      .i_alu_y(alu_y), .i_alu_finish(fin), .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
      .o_wb_data(wb_data), .o_wb_rd(wb_rd), .o_illegal(illegal), .o_err(err)
   );

   // behavioural ALU answering whatever strobe is presented
   always_comb begin
      alu_y = '0;
      case (alu_sel)
         10'h001: alu_y = alu_a + alu_b;
         10'h002: alu_y = alu_a - alu_b;
         10'h004: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
         10'h008: alu_y = {31'b0, alu_a < alu_b};
         10'h010: alu_y = alu_a ^ alu_b;
         10'h020: alu_y = alu_a | alu_b;
         10'h040: alu_y = alu_a & alu_b;
         10'h080: alu_y = alu_a << alu_b[4:0];
         10'h100: alu_y = alu_a >> alu_b[4:0];
         10'h200: alu_y = $signed(alu_a) >>> alu_b[4:0];
         default: alu_y = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference: what the instruction means, independent of how the block sequences it
   task automatic model();
      logic [31:0] x, z;
      logic [4:0]  sh;
      logic [2:0]  f;
      logic        alt;
      x = opcode == LUI ? 32'd0 : opcode == AUIPC ? pc : rs1;
      z = opcode == OP ? rs2 : imm;
      f = (opcode == LUI || opcode == AUIPC) ? 3'd0 : funct3;
      alt = funct7_5 && (f == 3'd5 || (f == 3'd0 && opcode == OP));
      sh = z[4:0];
      eb = z;
      case (f)
         3'd0: begin ey = alt ? x - z : x + z; es = alt ? 10'h002 : 10'h001; end
         3'd1: begin ey = x << sh; es = 10'h080; eb = {27'b0, sh}; end
         3'd2: begin ey = $signed(x) < $signed(z) ? 1 : 0; es = 10'h004; end
         3'd3: begin ey = x < z ? 1 : 0; es = 10'h008; end
         3'd4: begin ey = x ^ z; es = 10'h010; end
         3'd5: begin ey = alt ? 32'($signed(x) >>> sh) : x >> sh; es = alt ? 10'h200 : 10'h100; eb = {27'b0, sh}; end
         3'd6: begin ey = x | z; es = 10'h020; end
         default: begin ey = x & z; es = 10'h040; end
      endcase
      ea = x;
      erd = rd;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic [31:0] p, r1, r2, im, input logic [4:0] d);
      opcode = o; funct3 = f3; funct7_5 = f7; pc = p; rs1 = r1; rs2 = r2; imm = im; rd = d;
      id_valid = 1'b1;
      model();
   endtask

   // called at a negedge after drive(); ends in DONE with finish low
   task automatic accept_op(input int fin_dly);
      fin = fin_dly == 0;
      #1 chk("id_ready_accept", id_ready, 1);
      cyc();
      id_valid = 1'b0;
      wb_ready = 1'b0;
      chk("issue_sel", alu_sel, es);
      chk("issue_a", alu_a, ea);
      chk("issue_b", alu_b, eb);
      chk("issue_id_ready", id_ready, 0);
      chk("issue_wb_valid", wb_valid, 0);
      for (int i = 0; i < fin_dly; i++) begin
         cyc();
         chk("wait_sel", alu_sel, es);
         chk("wait_wb_valid", wb_valid, 0);
      end
      fin = 1'b1;
      cyc();
      fin = 1'b0;
      chk("done_wb_valid", wb_valid, 1);
      chk("done_data", wb_data, ey);
      chk("done_rd", wb_rd, erd);
      chk("done_sel", alu_sel, 0);
   endtask

   task automatic release_op(input int wb_dly);
      for (int i = 0; i < wb_dly; i++) begin
         cyc();
         chk("hold_valid", wb_valid, 1);
         chk("hold_data", wb_data, ey);
         chk("hold_rd", wb_rd, erd);
         chk("hold_id_ready", id_ready, 0);
      end
      wb_ready = 1'b1;
      #1 chk("release_id_ready", id_ready, 1);
      cyc();
      wb_ready = 1'b0;
      chk("release_valid", wb_valid, 0);
   endtask

   initial begin
      #12;
      chk("rst_sel", alu_sel, 0);
      chk("rst_ab", alu_a | alu_b, 0);
      chk("rst_wb", {wb_valid, illegal, err}, 0);
      chk("rst_data", wb_data, 0);
      chk("rst_rd", wb_rd, 0);
      chk("rst_c", {alu_c_e, alu_c}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("idle_ready", id_ready, 1);

      drive(OP, 3'd0, 1'b0, 0, 7, 5, 0, 5'd5);
      accept_op(0);
      chk("add_data_const", wb_data, 12);
      release_op(0);

      drive(OPI, 3'd5, 1'b1, 0, 32'h8000_0000, 0, 32'h4000_0423, 5'd9);
      chk("srai_b_const", eb, 3);
      accept_op(1);
      release_op(1);

      drive(OP, 3'd0, 1'b1, 0, 3, 5, 0, 5'd1);
      accept_op(0);
      chk("sub_data_const", wb_data, 32'hFFFF_FFFE);
      release_op(0);

      drive(LUI, 3'd3, 1'b1, 0, 32'hdead_beef, 0, 32'h1234_5000, 5'd2);
      accept_op(2);
      chk("lui_data_const", wb_data, 32'h1234_5000);
      release_op(0);

      drive(AUIPC, 3'd7, 1'b0, 32'h100, 32'h55, 0, 32'h1000, 5'd3);
      accept_op(0);
      chk("auipc_data_const", wb_data, 32'h1100);

      // hold in DONE, then back-to-back accept on the ready cycle
      release_op_hold: for (int i = 0; i < 5; i++) begin
         cyc();
         chk("b2b_hold_data", wb_data, 32'h1100);
         chk("b2b_hold_rd", wb_rd, 3);
         chk("b2b_hold_id_ready", id_ready, 0);
      end
      wb_ready = 1'b1;
      drive(OPI, 3'd0, 1'b1, 0, 100, 0, 32'hFFFF_FFFF, 5'd7);
      accept_op(0);
      chk("addi_not_sub", wb_data, 99);
      release_op(0);

      // illegal opcode
      drive(7'b1110011, 3'd0, 1'b0, 0, 1, 2, 3, 5'd4);
      cyc();
      id_valid = 1'b0;
      chk("illegal_pulse", illegal, 1);
      chk("illegal_sel", alu_sel, 0);
      chk("illegal_idle", id_ready, 1);
      cyc();
      chk("illegal_once", illegal, 0);
      chk("illegal_no_wb", wb_valid, 0);

      // timeout
      drive(OP, 3'd4, 1'b0, 0, 1, 2, 0, 5'd6);
      fin = 1'b0;
      cyc();
      id_valid = 1'b0;
      for (int k = 1; k <= TIMEOUT + 2; k++) begin
         cyc();
         chk("to_err", err, k == TIMEOUT + 1);
         chk("to_ready", id_ready, k > TIMEOUT);
         chk("to_no_wb", wb_valid, 0);
      end

      // flush in WAIT
      drive(OP, 3'd6, 1'b0, 0, 1, 2, 0, 5'd6);
      cyc();
      id_valid = 1'b0;
      cyc();
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flw_sel", alu_sel, 0);
      chk("flw_ready", id_ready, 1);
      for (int k = 0; k < TIMEOUT + 2; k++) begin
         cyc();
         chk("flw_no_err", {err, wb_valid}, 0);
      end

      // flush in DONE with a simultaneous handshake that must be dropped
      drive(OP, 3'd7, 1'b0, 0, 32'hF0, 32'h3C, 0, 5'd8);
      accept_op(0);
      drive(OP, 3'd0, 1'b0, 0, 1, 1, 0, 5'd9);
      flush = 1'b1;
      wb_ready = 1'b1;
      cyc();
      flush = 1'b0;
      wb_ready = 1'b0;
      id_valid = 1'b0;
      chk("fld_valid", wb_valid, 0);
      chk("fld_sel", alu_sel, 0);
      chk("fld_ready", id_ready, 1);
      cyc();
      chk("fld_no_issue", {alu_sel, wb_valid}, 0);

      // asynchronous reset in the middle of an op
      drive(OP, 3'd1, 1'b0, 0, 5, 3, 0, 5'd10);
      cyc();
      id_valid = 1'b0;
      cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_sel", alu_sel, 0);
      chk("mrst_ab", alu_a | alu_b, 0);
      chk("mrst_wb", {wb_valid, err}, 0);
      chk("mrst_ready", id_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("mrst_after", {wb_valid, err, alu_sel}, 0);

      for (int n = 0; n < 60; n++) begin
         logic [6:0] o;
         case ($urandom_range(0, 3))
            0: o = OP;
            1: o = OPI;
            2: o = LUI;
            default: o = AUIPC;
         endcase
         drive(o, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom));
         accept_op($urandom_range(0, 3));
         release_op($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
